// File: rtl/hit_event_arbiter_if.sv
// Detector/host-facing bus of hit_event_arbiter: hit and clear inputs, read handshake, status.
// The master side drives hits and read requests; the arbiter is the slave.
interface hit_event_arbiter_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] hit;
    logic           clr;
    logic           rd_req;
    logic [CHW-1:0] rd_ch;
    logic           rd_ack;
    logic [CW-1:0]  rd_data;
    logic           rd_ovf;
    logic [NCH-1:0] drop;
    logic           busy;

    modport master (
        output hit, clr, rd_req, rd_ch,
        input  rd_ack, rd_data, rd_ovf, drop, busy
    );

    modport slave (
        input  hit, clr, rd_req, rd_ch,
        output rd_ack, rd_data, rd_ovf, drop, busy
    );
endinterface

// File: rtl/hit_event_arbiter.sv
// Latches per-channel hit pulses and round-robin grants one channel per cycle to a shared counter.
// Define HIT_SAT_EN for saturating counts; the default build wraps at 2^CW-1 -> 0.
module hit_event_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    hit_event_arbiter_if.slave   bus
);
    localparam int          CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] MAXC = '1;

    typedef enum logic {IDLE, HOLD} rd_state_t;

    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] drop_q, drop_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [CHW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  count_q [NCH];
    logic [CW-1:0]  count_d [NCH];

    logic           grant_vld;
    logic [CHW-1:0] grant_idx;
    logic [NCH-1:0] grant_oh;

    rd_state_t      rd_state_q;
    logic           rd_ack_q;
    logic [CW-1:0]  rd_data_q;
    logic           rd_ovf_q;
    logic [CW-1:0]  rd_cnt_sel;
    logic           rd_ovf_sel;

    // Scan downward so the lowest offset from ptr is the one that sticks.
    always_comb begin : grant_scan
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (pending_q[idx]) begin
                grant_vld = 1'b1;
                grant_idx = CHW'(idx);
            end
        end
    end

    assign grant_oh = (grant_vld && !bus.clr) ? (NCH'(1) << grant_idx) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (bus.clr) begin
            ptr_d = '0;
        end else if (grant_vld) begin
            ptr_d = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic          at_max;
            logic [CW-1:0] inc_val;

            assign at_max = (count_q[gi] == MAXC);
`ifdef HIT_SAT_EN
            assign inc_val = at_max ? count_q[gi] : count_q[gi] + 1'b1;
`else
            assign inc_val = count_q[gi] + 1'b1;
`endif
            assign count_d[gi]   = bus.clr ? '0 : (grant_oh[gi] ? inc_val : count_q[gi]);
            assign ovf_d[gi]     = !bus.clr && (ovf_q[gi] || (grant_oh[gi] && at_max));
            // A hit on the channel being granted re-arms pending, so neither hit is lost.
            assign pending_d[gi] = !bus.clr && ((pending_q[gi] && !grant_oh[gi]) || bus.hit[gi]);
            assign drop_d[gi]    = !bus.clr &&
                                   (drop_q[gi] || (bus.hit[gi] && pending_q[gi] && !grant_oh[gi]));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            drop_q    <= '0;
            ovf_q     <= '0;
            ptr_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    always_comb begin
        rd_cnt_sel = '0;
        rd_ovf_sel = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.rd_ch == CHW'(i)) begin
                rd_cnt_sel = count_q[i];
                rd_ovf_sel = ovf_q[i];
            end
        end
    end

    // Capture uses pre-edge counts; one ack per request, re-armed only after rd_req drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state_q <= IDLE;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            rd_ack_q <= 1'b0;
            case (rd_state_q)
                IDLE: begin
                    if (bus.rd_req) begin
                        rd_data_q  <= rd_cnt_sel;
                        rd_ovf_q   <= rd_ovf_sel;
                        rd_ack_q   <= 1'b1;
                        rd_state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.rd_req) begin
                        rd_state_q <= IDLE;
                    end
                end
                default: rd_state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_ack  = rd_ack_q;
    assign bus.rd_data = rd_data_q;
    assign bus.rd_ovf  = rd_ovf_q;
    assign bus.drop    = drop_q;
    assign bus.busy    = |pending_q;
endmodule

// File: tb/tb_hit_event_arbiter.sv
// Directed bench for hit_event_arbiter (NCH=4, CW=8); expected values are hand-derived.
module tb_hit_event_arbiter;
    localparam int NCH = 4;
    localparam int CW  = 8;
`ifdef HIT_SAT_EN
    localparam logic [31:0] EXP_OVF_CNT = 32'd255;
`else
    localparam logic [31:0] EXP_OVF_CNT = 32'd0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hit_event_arbiter_if #(.NCH(NCH), .CW(CW)) bus ();

    hit_event_arbiter #(.NCH(NCH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        bus.hit    = '0;
        bus.clr    = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_ch  = '0;
        #3;
        check("rst_ack",  32'(bus.rd_ack),  32'd0);
        check("rst_data", 32'(bus.rd_data), 32'd0);
        check("rst_busy", 32'(bus.busy),    32'd0);
        check("rst_drop", 32'(bus.drop),    32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single hit on ch2, then read it back
        bus.hit = 4'b0100;
        tick();
        bus.hit = '0;
        check("hit2_busy", 32'(bus.busy), 32'd1);
        tick();
        check("hit2_cnt",  32'(dut.count_q[2]), 32'd1);
        check("hit2_idle", 32'(bus.busy), 32'd0);
        bus.rd_req = 1'b1;
        bus.rd_ch  = 2'd2;
        tick();
        check("rd2_ack",  32'(bus.rd_ack),  32'd1);
        check("rd2_data", 32'(bus.rd_data), 32'd1);
        check("rd2_ovf",  32'(bus.rd_ovf),  32'd0);
        tick();
        check("rd2_ack_lo", 32'(bus.rd_ack), 32'd0);
        bus.rd_req = 1'b0;
        tick();

        // All four channels at once: grants 0,1,2,3 from a cleared pointer
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        bus.hit = 4'b1111;
        tick();
        bus.hit = '0;
        check("all_busy0", 32'(bus.busy), 32'd1);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check($sformatf("all_cnt%0d", j - 1), 32'(dut.count_q[j - 1]), 32'd1);
            if (j < 4) begin
                check($sformatf("all_nxt%0d", j), 32'(dut.count_q[j]), 32'd0);
                check($sformatf("all_busy%0d", j), 32'(bus.busy), 32'd1);
            end else begin
                check("all_busy_end", 32'(bus.busy), 32'd0);
            end
        end
        check("all_drop", 32'(bus.drop), 32'd0);

        // ch1 hit held three cycles while 0,2,3 pending
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        bus.hit = 4'b1111;
        tick();
        bus.hit = 4'b0010;
        tick();
        check("drop_set", 32'(bus.drop), 32'h2);
        tick();
        check("drop_cnt1a", 32'(dut.count_q[1]), 32'd1);
        bus.hit = '0;
        repeat (4) tick();
        check("drop_cnt1", 32'(dut.count_q[1]), 32'd2);
        check("drop_cnt3", 32'(dut.count_q[3]), 32'd1);
        check("drop_busy", 32'(bus.busy), 32'd0);
        check("drop_keep", 32'(bus.drop), 32'h2);

        // 256 grants on ch0
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        bus.hit = 4'b0001;
        repeat (256) tick();
        check("ovf_cnt255", 32'(dut.count_q[0]), 32'd255);
        check("ovf_not_yet", 32'(dut.ovf_q[0]), 32'd0);
        bus.hit = '0;
        tick();
        check("ovf_cnt", 32'(dut.count_q[0]), EXP_OVF_CNT);
        check("ovf_drop", 32'(bus.drop), 32'd0);
        check("ovf_busy", 32'(bus.busy), 32'd0);
        bus.rd_req = 1'b1;
        bus.rd_ch  = 2'd0;
        tick();
        check("rd0_ack",  32'(bus.rd_ack),  32'd1);
        check("rd0_data", 32'(bus.rd_data), EXP_OVF_CNT);
        check("rd0_ovf",  32'(bus.rd_ovf),  32'd1);
        tick();
        bus.rd_req = 1'b0;
        tick();

        // clr on the same edge as hit[3]
        bus.hit = 4'b1000;
        bus.clr = 1'b1;
        tick();
        bus.hit = '0;
        bus.clr = 1'b0;
        check("clr_busy",  32'(bus.busy), 32'd0);
        check("clr_drop",  32'(bus.drop), 32'd0);
        check("clr_ptr",   32'(dut.ptr_q), 32'd0);
        check("clr_ovf",   32'(dut.ovf_q), 32'd0);
        check("clr_cnt0",  32'(dut.count_q[0]), 32'd0);
        check("clr_rdkeep", 32'(bus.rd_ovf), 32'd1);
        tick();
        check("clr_cnt3",  32'(dut.count_q[3]), 32'd0);

        // Held read on ch1 while ch1 increments
        bus.hit = 4'b0010;
        tick();
        bus.hit    = '0;
        bus.rd_req = 1'b1;
        bus.rd_ch  = 2'd1;
        tick();
        check("hold_ack",  32'(bus.rd_ack),  32'd1);
        check("hold_data", 32'(bus.rd_data), 32'd0);
        check("hold_cnt1", 32'(dut.count_q[1]), 32'd1);
        bus.hit = 4'b0010;
        tick();
        bus.hit = '0;
        check("hold_ack1", 32'(bus.rd_ack), 32'd0);
        tick();
        tick();
        check("hold_ack3",  32'(bus.rd_ack),  32'd0);
        check("hold_dkeep", 32'(bus.rd_data), 32'd0);
        check("hold_cnt1b", 32'(dut.count_q[1]), 32'd2);
        tick();
        check("hold_ack4", 32'(bus.rd_ack), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("hrst_ack",  32'(bus.rd_ack),  32'd0);
        check("hrst_data", 32'(bus.rd_data), 32'd0);
        check("hrst_cnt1", 32'(dut.count_q[1]), 32'd0);
        #1 reset = 1'b1;
        tick();
        check("hrst_idle_ack", 32'(bus.rd_ack), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("hrst_ack_drop", 32'(bus.rd_ack), 32'd0);
        #1 reset = 1'b1;
        bus.rd_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hit_event_arbiter.md
# hit_event_arbiter

Shared event-counting back end for a bank of serial pattern detectors. Each detector channel raises a one-cycle `hit` pulse per detected occurrence. This block latches the hits and grants one channel per cycle to a single shared increment datapath using round-robin arbitration. It keeps a per-channel occurrence count and serves host reads of any channel's count over a req/ack handshake.

## Interface
- `NCH`, 4, number of detector channels (2..16)
- `CW`, 8, width of each per-channel count
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `hit`  in  NCH  per-channel detection pulse, sampled at posedge clk
- `clr`  in  1  synchronous clear of counts, pending, drop, ovf and pointer
- `rd_req`  in  1  level read request
- `rd_ch`  in  $clog2(NCH)  channel to read, stable while `rd_req`=1
- `rd_ack`  out  1  one-cycle pulse: `rd_data`/`rd_ovf` valid
- `rd_data`  out  CW  captured count of `rd_ch`
- `rd_ovf`  out  1  captured overflow flag of `rd_ch`
- `drop`  out  NCH  sticky: a hit was lost on that channel
- `busy`  out  1  OR of all pending bits

## Operation
- Reset (`reset`=0, async) clears everything:
  - counts, pending, drop, ovf, rr pointer = 0
  - `rd_ack`=0, `rd_data`=0, `rd_ovf`=0, `busy`=0
  - read FSM = IDLE
- Pending: `pending[i]` sets on an edge with `hit[i]`=1.
- Grant:
  - Each edge with any pending bit, grant channel g = first pending bit scanning from `ptr` upward, modulo NCH.
  - `count[g]` increments; `pending[g]` clears; `ptr` <= (g+1) mod NCH.
  - `ptr` is unchanged when nothing is pending.
- Simultaneous hit on granted channel g: `pending[g]` stays set, so both hits are counted.
- Hit on channel i while `pending[i]`=1 and i not granted: the hit is lost, and `drop[i]` <= 1 (sticky).
- Increment at `count`=2^CW-1: `ovf[i]` <= 1 (sticky). Count result depends on HIT_SAT_EN.
- `clr`=1 at an edge:
  - Zeroes counts, pending, drop, ovf and `ptr`.
  - Hits sampled on that edge are discarded.
  - No grant occurs on that edge.
  - Read FSM and read outputs are unaffected.
- Read FSM, states IDLE and HOLD:
  - IDLE, `rd_req`=1: capture `rd_data` <= `count[rd_ch]` and `rd_ovf` <= `ovf[rd_ch]`, using pre-edge values (an increment on the same edge is not included). Set `rd_ack` <= 1, go to HOLD.
  - HOLD: `rd_ack` <= 0. Stay while `rd_req`=1; go to IDLE on the edge `rd_req` is sampled 0.
  - `rd_data`/`rd_ovf` hold their value until the next capture.
- Reads never stall grants; the count array is read combinationally.

## Timing
- Hit to count update:
  - Hit sampled at edge k; earliest increment at edge k+1 (channel granted immediately).
  - Worst case edge k+NCH under full contention.
- `busy` is combinational from the pending registers. It goes high the cycle after the hit edge and low the cycle after the last grant.
- Read: `rd_req` sampled high at edge k gives `rd_ack`=1 during cycle k..k+1, then low from edge k+1.
  - A held `rd_req` never produces a second ack.
  - A new read requires `rd_req` to drop for at least one sampled edge.
- Reset asserted mid-read drops `rd_ack` immediately. The FSM restarts in IDLE.

## Configuration
- `HIT_SAT_EN` defined:
  - Counts saturate at 2^CW-1; further grants leave the value unchanged.
  - `ovf` is still set.
- `HIT_SAT_EN` undefined:
  - Counts wrap 2^CW-1 -> 0; `ovf` is set on the wrap.
- Arbitration, drop and read behaviour are identical in both builds.

## Test plan
- Reset, then single `hit[2]` pulse -> `count[2]`=1 one edge later; read ch2 gives `rd_data`=1, `rd_ack` high exactly one cycle.
- `hit`=4'b1111 for one cycle -> grants in order 0,1,2,3 over four edges; all counts =1; `busy` high 4 cycles; no drops.
- `hit[1]` held high 3 cycles while ch0,2,3 also pending -> `drop[1]`=1; `count[1]`=2.
- 256 grants on ch0 with CW=8 -> HIT_SAT_EN build: `count[0]`=255, `rd_ovf`=1; non-SAT build: `count[0]`=0, `rd_ovf`=1.
- `clr` on the same edge as `hit[3]` -> all counts/drop/ovf =0, `count[3]` stays 0, `ptr`=0.
- `rd_req` held 5 cycles on ch1 while ch1 increments -> single ack carrying the pre-edge value; reset asserted during HOLD -> `rd_ack`=0, FSM IDLE, `rd_data`=0.
